// File: rtl/div_iter.sv
// Iterative signed restoring divider, MIPS DIV semantics: quotient on div_low_out, remainder on div_high_out.
// Optional DIV_EARLY_TERM_EN: operations with |A| < |B| finish right after PREP.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] div_high_out,
  output logic [WIDTH-1:0] div_low_out,
  output logic             div_end,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           r_state, w_next;
  logic             r_divctrl_q, r_zero, r_sign_q, r_sign_r;
  logic [WIDTH-1:0] r_a, r_b, r_quo;
  logic [WIDTH:0]   r_rem, r_absb;
  logic [CW-1:0]    r_cnt;
  logic             w_start, w_early, w_last;
  logic [WIDTH:0]   w_sa, w_sb, w_absa, w_absb, w_shift, w_trial;

  assign w_start = DivCtrl & ~r_divctrl_q;
  assign w_last  = (r_cnt == CW'(WIDTH-1));

  // One extra bit so |0x80000000| is exact
  assign w_sa   = {r_a[WIDTH-1], r_a};
  assign w_sb   = {r_b[WIDTH-1], r_b};
  assign w_absa = r_a[WIDTH-1] ? (~w_sa + 1'b1) : w_sa;
  assign w_absb = r_b[WIDTH-1] ? (~w_sb + 1'b1) : w_sb;

  assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_trial = w_shift - r_absb;

`ifdef DIV_EARLY_TERM_EN
  assign w_early = (w_absa < w_absb);
`else
  assign w_early = 1'b0;
`endif

  assign div_end  = (r_state == S_DONE);
  assign div_zero = (r_state == S_DONE) & r_zero;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = (B == '0) ? S_DONE : S_PREP;
      S_PREP: w_next = w_early ? S_DONE : S_ITER;
      S_ITER: if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_divctrl_q  <= 1'b0;
      r_zero       <= 1'b0;
      r_sign_q     <= 1'b0;
      r_sign_r     <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_absb       <= '0;
      r_cnt        <= '0;
      div_high_out <= '0;
      div_low_out  <= '0;
    end else begin
      r_state     <= w_next;
      r_divctrl_q <= DivCtrl;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_a    <= A;
          r_b    <= B;
          r_zero <= (B == '0);
        end
        S_PREP: begin
          r_absb   <= w_absb;
          r_quo    <= w_absa[WIDTH-1:0];
          r_rem    <= '0;
          r_sign_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_sign_r <= r_a[WIDTH-1];
          r_cnt    <= '0;
          if (w_early) begin
            div_low_out  <= '0;
            div_high_out <= r_a;
          end
        end
        S_ITER: begin
          // Trial subtraction; the sign bit of the WIDTH+1 result selects keep vs restore
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial;
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift;
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        S_FIX: begin
          div_low_out  <= r_sign_q ? (~r_quo + 1'b1) : r_quo;
          div_high_out <= r_sign_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: signed results, overflow, divide-by-zero, abort by reset, held start.
// Latency is counted in rising edges after DivCtrl is raised, up to the edge that asserts div_end.
module tb_div_iter;
  logic        clk = 1'b0;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] A, B;
  logic [31:0] div_high_out, div_low_out;
  logic        div_end, div_zero;

  int n_chk = 0;
  int n_err = 0;
  int lat;
  int ends;
  logic zf;
  int exp_early_lat;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .DivCtrl(DivCtrl), .A(A), .B(B),
    .div_high_out(div_high_out), .div_low_out(div_low_out),
    .div_end(div_end), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise DivCtrl, scramble A/B once the operands are latched, wait (bounded) for div_end.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                        output int l, output logic z);
    @(negedge clk);
    A = a; B = b; DivCtrl = 1'b1;
    l = 999; z = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) begin A = $urandom; B = $urandom; end
      if (div_end) begin l = i; z = div_zero; break; end
    end
    if (!hold) DivCtrl = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input int el, input logic ez);
    int l;
    logic z;
    run_op(a, b, 1'b0, l, z);
    chk({tag, ".lat"}, 32'(l), 32'(el));
    chk({tag, ".zero"}, {31'd0, z}, {31'd0, ez});
    chk({tag, ".quo"}, div_low_out, eq);
    chk({tag, ".rem"}, div_high_out, er);
    @(negedge clk);
    chk({tag, ".pulse"}, {31'd0, div_end}, 32'd0);
  endtask

  initial begin
`ifdef DIV_EARLY_TERM_EN
    exp_early_lat = 2;
`else
    exp_early_lat = 35;
`endif
    reset = 1'b0; DivCtrl = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("rst.hi",   div_high_out, 32'd0);
    chk("rst.lo",   div_low_out,  32'd0);
    chk("rst.end",  {31'd0, div_end},  32'd0);
    chk("rst.zero", {31'd0, div_zero}, 32'd0);

    op_chk("p_p",   32'd100,        32'd7,          32'd14,         32'd2,          35, 1'b0);
    op_chk("n_p",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   35, 1'b0);
    op_chk("p_n",   32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          35, 1'b0);
    op_chk("n_n",   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   35, 1'b0);
    op_chk("ovf",   32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          35, 1'b0);
    op_chk("min_1", 32'h80000000,   32'd1,          32'h80000000,   32'd0,          35, 1'b0);
    op_chk("big",   32'h7FFFFFFF,   32'h00010000,   32'h00007FFF,   32'h0000FFFF,   35, 1'b0);
    op_chk("p_p2",  32'd100,        32'd7,          32'd14,         32'd2,          35, 1'b0);
    // Divide by zero leaves the previous 14/2 in place
    op_chk("dz",    32'd5,          32'd0,          32'd14,         32'd2,          1,  1'b1);
    op_chk("small", 32'd3,          32'd10,         32'd0,          32'd3,          exp_early_lat, 1'b0);
    op_chk("zero_a",32'd0,          32'd9,          32'd0,          32'd0,          exp_early_lat, 1'b0);

    op_chk("p_p3",  32'd100,        32'd7,          32'd14,         32'd2,          35, 1'b0);
    // Abort by reset 10 cycles into an operation
    @(negedge clk);
    A = 32'd100; B = 32'd7; DivCtrl = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0; DivCtrl = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort.hi",  div_high_out, 32'd0);
    chk("abort.lo",  div_low_out,  32'd0);
    ends = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_end) ends++;
    end
    chk("abort.noend", 32'(ends), 32'd0);
    op_chk("fresh", 32'd100, 32'd7, 32'd14, 32'd2, 35, 1'b0);

    // DivCtrl held high through DONE must not start a second operation
    run_op(32'd50, 32'd6, 1'b1, lat, zf);
    chk("hold.lat", 32'(lat), 32'd35);
    chk("hold.quo", div_low_out, 32'd8);
    chk("hold.rem", div_high_out, 32'd2);
    ends = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_end) ends++;
    end
    chk("hold.noend", 32'(ends), 32'd0);
    DivCtrl = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
